// File: rtl/ad7276_spi_capture.sv
// Dual AD7276 serial capture: shared cs/sclk framing, 16-clock frames on a fixed sample period,
// followed by a two-stage offset/gain pipeline producing signed Q16.16-scaled results.
module ad7276_spi_capture #(
  parameter int ADC_LENGTH    = 12,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic                    CLK100MHz,
  input  logic                    ARESETN,
  input  logic                    start_en,
  input  logic                    in_adc1,
  input  logic                    in_adc2,
  input  logic [ADC_LENGTH-1:0]   offset,
  input  logic [31:0]             gain,
  output logic                    cs,
  output logic                    sclk,
  output logic signed [31:0]      adc1,
  output logic signed [31:0]      adc2,
  output logic [ADC_LENGTH-1:0]   raw1,
  output logic [ADC_LENGTH-1:0]   raw2,
  output logic                    eoc_adc
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W  = $clog2(SAMPLE_PERIOD);
  localparam int DIFF_W = ADC_LENGTH + 1;
  localparam int PROD_W = DIFF_W + 32;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end
  if (SAMPLE_PERIOD < 32*CLK_DIV + 4) begin : g_bad_period
    $error("SAMPLE_PERIOD must be at least 32*CLK_DIV+4");
  end

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, CALC, WAIT} state_t;

  state_t                       state_q, state_d;
  logic [DIV_W-1:0]             div_q, div_d;
  logic [4:0]                   half_q, half_d;
  logic [PER_W-1:0]             per_q, per_d;
  logic                         cs_q, cs_d, sclk_q, sclk_d;
  logic                         sample_en;
  logic [ADC_LENGTH-1:0]        sr1_q, sr2_q;
  logic                         vld_p1, eoc_q;
  logic signed [DIFF_W-1:0]     diff1_p1, diff2_p1;
  logic [31:0]                  gain_p1;
  logic [ADC_LENGTH-1:0]        raw1_q, raw2_q;
  logic signed [31:0]           adc1_q, adc2_q;

  function automatic logic signed [DIFF_W-1:0] offset_diff(input logic [ADC_LENGTH-1:0] code,
                                                           input logic [ADC_LENGTH-1:0] zero);
    return $signed({1'b0, code}) - $signed({1'b0, zero});
  endfunction

  // Truncating (floor) scale; the product cannot exceed 32 bits after the shift, so no clamp.
  function automatic logic signed [31:0] scale_q16(input logic signed [DIFF_W-1:0] d,
                                                   input logic [31:0] g);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(d) * $signed({{DIFF_W{1'b0}}, g});
    return 32'(prod >>> 16);
  endfunction

  // Sample on the cycle sclk rises; only bit indices carrying D11..D0 enter the shift register.
  assign sample_en = (state_q == SHIFT) && (div_q == DIV_W'(CLK_DIV-1)) && !half_q[0] &&
                     (half_q[4:1] >= 4'd2) && (half_q[4:1] <= 4'(ADC_LENGTH+1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    per_d   = per_q + 1'b1;
    case (state_q)
      IDLE: begin
        per_d = '0;
        if (start_en) state_d = SETUP;
      end
      SETUP: begin
        state_d = SHIFT;
        div_d   = '0;
        half_d  = '0;
      end
      SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV-1)) begin
          div_d  = '0;
          half_d = half_q + 5'd1;
          if (half_q == 5'd31) state_d = CALC;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      CALC: state_d = WAIT;
      WAIT: begin
        if (per_q == PER_W'(SAMPLE_PERIOD-1)) state_d = start_en ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == SETUP) per_d = '0;
    cs_d   = !((state_d == SETUP) || (state_d == SHIFT));
    sclk_d = (state_d == SHIFT) ? half_d[0] : 1'b1;
  end

  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      per_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      vld_p1  <= 1'b0;
      eoc_q   <= 1'b0;
      raw1_q  <= '0;
      raw2_q  <= '0;
      adc1_q  <= '0;
      adc2_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      per_q   <= per_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      // Stage 1: latch codes, remove offset, snapshot gain
      vld_p1  <= (state_q == CALC);
      if (state_q == CALC) begin
        raw1_q <= sr1_q;
        raw2_q <= sr2_q;
      end
      // Stage 2: apply gain
      eoc_q <= vld_p1;
      if (vld_p1) begin
        adc1_q <= scale_q16(diff1_p1, gain_p1);
        adc2_q <= scale_q16(diff2_p1, gain_p1);
      end
    end
  end

  always_ff @(posedge CLK100MHz) begin
    if (sample_en) begin
      sr1_q <= {sr1_q[ADC_LENGTH-2:0], in_adc1};
      sr2_q <= {sr2_q[ADC_LENGTH-2:0], in_adc2};
    end
    if (state_q == CALC) begin
      diff1_p1 <= offset_diff(sr1_q, offset);
      diff2_p1 <= offset_diff(sr2_q, offset);
      gain_p1  <= gain;
    end
  end

  assign cs      = cs_q;
  assign sclk    = sclk_q;
  assign adc1    = adc1_q;
  assign adc2    = adc2_q;
  assign raw1    = raw1_q;
  assign raw2    = raw2_q;
  assign eoc_adc = eoc_q;

endmodule

// File: tb/tb_ad7276_spi_capture.sv
// Directed bench for ad7276_spi_capture with a two-converter serial model (CLK_DIV=2, SAMPLE_PERIOD=80).
module tb_ad7276_spi_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_en = 1'b0;
  logic in1 = 1'b0, in2 = 1'b0;
  logic [11:0] offset = 12'd2047;
  logic [31:0] gain = 32'd655;
  logic cs, sclk, eoc;
  logic signed [31:0] adc1, adc2;
  logic [11:0] raw1, raw2;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, eoc_cnt = 0, rise_cnt = 0;
  logic [11:0] w1 = 12'h000, w2 = 12'h000;
  int nb = 0;

  ad7276_spi_capture #(.ADC_LENGTH(12), .CLK_DIV(2), .SAMPLE_PERIOD(80)) dut (
    .CLK100MHz(clk), .ARESETN(rst_n), .start_en(start_en), .in_adc1(in1), .in_adc2(in2),
    .offset(offset), .gain(gain), .cs(cs), .sclk(sclk), .adc1(adc1), .adc2(adc2),
    .raw1(raw1), .raw2(raw2), .eoc_adc(eoc));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eoc === 1'b1) eoc_cnt <= eoc_cnt + 1;
  end
  always @(posedge sclk) rise_cnt <= rise_cnt + 1;

  // Converter model: bits 0-1 zero, 2..13 carry D11..D0, 14-15 zero; next bit presented after each sclk fall
  function automatic logic bitv(input logic [11:0] w, input int b);
    if (b >= 2 && b <= 13) return w[13-b];
    return 1'b0;
  endfunction

  always @(negedge sclk or posedge cs) begin
    if (cs) begin
      nb  <= 0;
      in1 <= 1'b0;
      in2 <= 1'b0;
    end else begin
      in1 <= bitv(w1, nb);
      in2 <= bitv(w2, nb);
      nb  <= nb + 1;
    end
  end

  task automatic wait_cs(input logic v, input string nm);
    int k = 0;
    while (cs !== v && k < 400) begin @(negedge clk); k++; end
    n_cmp++;
    if (cs !== v) begin $display("FAIL %s: cs timeout, got %b want %b", nm, cs, v); n_fail++; end
  endtask

  task automatic wait_eoc(input string nm);
    int k = 0;
    while (eoc !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    n_cmp++;
    if (eoc !== 1'b1) begin $display("FAIL %s: eoc_adc timeout, got %b want 1", nm, eoc); n_fail++; end
  endtask

  task automatic wait_rises(input int r0, input int n);
    for (int k = 0; k < 200 && (rise_cnt - r0) < n; k++) @(negedge clk);
  endtask

  task automatic kick(input string nm);
    @(negedge clk);
    start_en = 1'b1;
    wait_cs(1'b0, nm);
    start_en = 1'b0;
  endtask

  task automatic run_frame(input logic [11:0] a, input logic [11:0] b, input string nm);
    w1 = a; w2 = b;
    kick(nm);
    wait_cs(1'b1, nm);
    wait_eoc(nm);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (cs !== 1'b1) begin $display("FAIL reset_cs: got %b want 1", cs); n_fail++; end
    n_cmp++; if (sclk !== 1'b1) begin $display("FAIL reset_sclk: got %b want 1", sclk); n_fail++; end
    n_cmp++; if (eoc !== 1'b0) begin $display("FAIL reset_eoc: got %b want 0", eoc); n_fail++; end
    n_cmp++; if (adc1 !== 32'd0 || adc2 !== 32'd0) begin
      $display("FAIL reset_adc: got %h/%h want 0/0", adc1, adc2); n_fail++; end
    n_cmp++; if (raw1 !== 12'd0 || raw2 !== 12'd0) begin
      $display("FAIL reset_raw: got %h/%h want 0/0", raw1, raw2); n_fail++; end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (cs !== 1'b1) begin $display("FAIL idle_cs: got %b want 1", cs); n_fail++; end
  endtask

  task automatic test_basic;
    int t_fall, t_rise;
    w1 = 12'hA5C; w2 = 12'hFFF;
    @(negedge clk);
    start_en = 1'b1;
    @(negedge clk);
    start_en = 1'b0;
    n_cmp++; if (cs !== 1'b0) begin $display("FAIL start_latency: cs got %b want 0", cs); n_fail++; end
    t_fall = cyc;
    wait_cs(1'b1, "basic_rise");
    n_cmp++; if (cyc - t_fall != 65) begin
      $display("FAIL cs_low_len: got %0d want 65", cyc - t_fall); n_fail++; end
    t_rise = cyc;
    wait_eoc("basic_eoc");
    n_cmp++; if (cyc - t_rise != 2) begin
      $display("FAIL eoc_latency: got %0d want 2", cyc - t_rise); n_fail++; end
    n_cmp++; if (raw1 !== 12'hA5C || raw2 !== 12'hFFF) begin
      $display("FAIL basic_raw: got %h/%h want a5c/fff", raw1, raw2); n_fail++; end
    n_cmp++; if (adc1 !== 32'sd6 || adc2 !== 32'sd20) begin
      $display("FAIL basic_adc: got %0d/%0d want 6/20", adc1, adc2); n_fail++; end
    @(negedge clk);
    n_cmp++; if (eoc !== 1'b0) begin $display("FAIL eoc_width: got %b want 0", eoc); n_fail++; end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_codes;
    run_frame(12'h000, 12'hFFF, "code_zero");
    n_cmp++; if (adc1 !== 32'hFFFFFFEB || raw1 !== 12'h000) begin
      $display("FAIL code_zero: got adc %h raw %h want ffffffeb/000", adc1, raw1); n_fail++; end
    run_frame(12'h7FF, 12'h000, "code_mid");
    n_cmp++; if (adc1 !== 32'd0 || raw1 !== 12'h7FF) begin
      $display("FAIL code_mid: got adc %h raw %h want 00000000/7ff", adc1, raw1); n_fail++; end
    n_cmp++; if (adc2 !== 32'hFFFFFFEB) begin
      $display("FAIL code_mid_ch2: got %h want ffffffeb", adc2); n_fail++; end
  endtask

  task automatic test_back_to_back;
    int tf[5];
    int e0, r0;
    w1 = 12'hA5C; w2 = 12'hFFF;
    e0 = eoc_cnt;
    @(negedge clk);
    start_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_cs(1'b0, "b2b_fall");
      tf[f] = cyc;
      r0 = rise_cnt;
      if (f == 4) start_en = 1'b0;
      if (f > 0) begin
        n_cmp++; if (tf[f] - tf[f-1] != 80) begin
          $display("FAIL b2b_period: frame %0d got %0d want 80", f, tf[f] - tf[f-1]); n_fail++; end
      end
      wait_cs(1'b1, "b2b_rise");
      n_cmp++; if (cyc - tf[f] != 65) begin
        $display("FAIL b2b_low: frame %0d got %0d want 65", f, cyc - tf[f]); n_fail++; end
      n_cmp++; if (rise_cnt - r0 != 16) begin
        $display("FAIL b2b_sclk: frame %0d got %0d want 16", f, rise_cnt - r0); n_fail++; end
    end
    repeat (150) @(negedge clk);
    n_cmp++; if (eoc_cnt - e0 != 5) begin
      $display("FAIL b2b_eoc: got %0d want 5", eoc_cnt - e0); n_fail++; end
    n_cmp++; if (cs !== 1'b1 || adc1 !== 32'sd6) begin
      $display("FAIL b2b_end: cs %b adc1 %0d want 1/6", cs, adc1); n_fail++; end
  endtask

  task automatic test_start_drop;
    int e0, r0;
    w1 = 12'h123; w2 = 12'h800;
    e0 = eoc_cnt;
    @(negedge clk);
    start_en = 1'b1;
    wait_cs(1'b0, "drop_fall");
    r0 = rise_cnt;
    wait_rises(r0, 8);
    start_en = 1'b0;
    wait_eoc("drop_eoc");
    n_cmp++; if (raw1 !== 12'h123 || raw2 !== 12'h800) begin
      $display("FAIL drop_raw: got %h/%h want 123/800", raw1, raw2); n_fail++; end
    n_cmp++; if (adc1 !== 32'hFFFFFFEE || adc2 !== 32'd0) begin
      $display("FAIL drop_adc: got %h/%h want ffffffee/00000000", adc1, adc2); n_fail++; end
    repeat (150) @(negedge clk);
    n_cmp++; if (eoc_cnt - e0 != 1 || cs !== 1'b1) begin
      $display("FAIL drop_after: eoc count %0d cs %b want 1/1", eoc_cnt - e0, cs); n_fail++; end
  endtask

  task automatic test_reset_mid;
    int e0, r0;
    w1 = 12'hA5C; w2 = 12'hFFF;
    e0 = eoc_cnt;
    kick("rmid_fall");
    r0 = rise_cnt;
    wait_rises(r0, 10);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (cs !== 1'b1 || sclk !== 1'b1) begin
      $display("FAIL rmid_pins: cs %b sclk %b want 1/1", cs, sclk); n_fail++; end
    n_cmp++; if (adc1 !== 32'd0 || raw1 !== 12'd0 || eoc !== 1'b0) begin
      $display("FAIL rmid_outs: adc1 %h raw1 %h eoc %b want 0/0/0", adc1, raw1, eoc); n_fail++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    n_cmp++; if (eoc_cnt - e0 != 0 || cs !== 1'b1) begin
      $display("FAIL rmid_no_eoc: eoc count %0d cs %b want 0/1", eoc_cnt - e0, cs); n_fail++; end
    run_frame(12'hA5C, 12'hFFF, "rmid_next");
    n_cmp++; if (raw1 !== 12'hA5C || adc1 !== 32'sd6 || adc2 !== 32'sd20) begin
      $display("FAIL rmid_next: raw1 %h adc1 %0d adc2 %0d want a5c/6/20", raw1, adc1, adc2); n_fail++; end
  endtask

  task automatic test_gain;
    int r0;
    w1 = 12'hA5C; w2 = 12'hFFF;
    gain = 32'd655;
    kick("gain_shift");
    r0 = rise_cnt;
    wait_rises(r0, 5);
    gain = 32'd1310;
    wait_eoc("gain_shift_eoc");
    n_cmp++; if (adc1 !== 32'sd12 || adc2 !== 32'sd40) begin
      $display("FAIL gain_shift: got %0d/%0d want 12/40", adc1, adc2); n_fail++; end
    repeat (20) @(negedge clk);
    gain = 32'd655;
    kick("gain_late");
    wait_cs(1'b1, "gain_late_rise");
    @(negedge clk);
    gain = 32'd1310;
    wait_eoc("gain_late_eoc");
    n_cmp++; if (adc1 !== 32'sd6 || adc2 !== 32'sd20) begin
      $display("FAIL gain_late: got %0d/%0d want 6/20", adc1, adc2); n_fail++; end
    repeat (20) @(negedge clk);
    run_frame(12'hA5C, 12'hFFF, "gain_next");
    n_cmp++; if (adc1 !== 32'sd12 || adc2 !== 32'sd40) begin
      $display("FAIL gain_next: got %0d/%0d want 12/40", adc1, adc2); n_fail++; end
    gain = 32'd655;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_codes;
    test_back_to_back;
    test_start_drop;
    test_reset_mid;
    test_gain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
